// File: rtl/encoder83.sv
// 8-to-3 priority encoder with registered index, any-request and multi-request flags.
// Bit 7 has the highest priority; outputs appear one enabled clock after the sample.
module encoder83 (
    input  logic       clk,
    input  logic       rst,
    input  logic       iEn,
    input  logic [7:0] iData,
    output logic [2:0] oData,
    output logic       oValid,
    output logic       oMulti
);

    // Highest-numbered set bit; an all-zero vector maps to 0 and is qualified by the valid flag.
    function automatic logic [2:0] prio_idx(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int n = 0; n < 8; n++) begin
            if (req[n]) begin
                idx = 3'(n);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic has_multi(input logic [7:0] req);
        return (req & (req - 8'd1)) != 8'd0;
    endfunction

    logic [2:0] idx_p0;
    logic       vld_p0;
    logic       multi_p0;

    logic [2:0] idx_p1;
    logic       vld_p1;
    logic       multi_p1;

    always_comb begin
        idx_p0   = prio_idx(iData);
        vld_p0   = |iData;
        multi_p0 = has_multi(iData);
    end

    // p0 -> p1: sample on enabled edges; reset clears index and flags without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_p1   <= 3'd0;
            vld_p1   <= 1'b0;
            multi_p1 <= 1'b0;
        end else if (iEn) begin
            idx_p1   <= idx_p0;
            vld_p1   <= vld_p0;
            multi_p1 <= multi_p0;
        end
    end

    assign oData  = idx_p1;
    assign oValid = vld_p1;
    assign oMulti = multi_p1;

endmodule

// File: tb/tb_encoder83.sv
// Directed bench for encoder83: one-hot sweep, priority, zero input, enable hold and async reset.
module tb_encoder83;

    logic       clk;
    logic       rst;
    logic       iEn;
    logic [7:0] iData;
    logic [2:0] oData;
    logic       oValid;
    logic       oMulti;

    int checks = 0;
    int errors = 0;

    encoder83 dut (
        .clk    (clk),
        .rst    (rst),
        .iEn    (iEn),
        .iData  (iData),
        .oData  (oData),
        .oValid (oValid),
        .oMulti (oMulti)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [2:0] exp_data,
                       input logic exp_valid, input logic exp_multi);
        checks++;
        assert (oData === exp_data)
        else begin
            errors++;
            $error("FAIL %s oData observed=%0d expected=%0d", tag, oData, exp_data);
        end
        checks++;
        assert (oValid === exp_valid)
        else begin
            errors++;
            $error("FAIL %s oValid observed=%b expected=%b", tag, oValid, exp_valid);
        end
        checks++;
        assert (oMulti === exp_multi)
        else begin
            errors++;
            $error("FAIL %s oMulti observed=%b expected=%b", tag, oMulti, exp_multi);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        iEn   = 1'b0;
        iData = 8'h00;
        #2;
        chk("reset_initial", 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        iEn = 1'b1;

        // One-hot sweep, each held for three edges.
        iData = 8'b1000_0000; tick(); chk("onehot7", 3'd7, 1'b1, 1'b0);
        tick(); tick();       chk("onehot7_hold", 3'd7, 1'b1, 1'b0);
        iData = 8'b0100_0000; tick(); chk("onehot6", 3'd6, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0010_0000; tick(); chk("onehot5", 3'd5, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0001_0000; tick(); chk("onehot4", 3'd4, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0000_1000; tick(); chk("onehot3", 3'd3, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0000_0100; tick(); chk("onehot2", 3'd2, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0000_0010; tick(); chk("onehot1", 3'd1, 1'b1, 1'b0); tick(); tick();
        iData = 8'b0000_0001; tick(); chk("onehot0", 3'd0, 1'b1, 1'b0); tick(); tick();
        iData = 8'b1000_0000; tick(); chk("onehot7_again", 3'd7, 1'b1, 1'b0);

        // Latency: a mid-cycle change must not reach the outputs before the next edge.
        #3;
        iData = 8'b0000_0010;
        #2;
        chk("no_comb_path", 3'd7, 1'b1, 1'b0);
        tick();               chk("latency_one", 3'd1, 1'b1, 1'b0);

        // Priority and multi-hot.
        iData = 8'b0010_0101; tick(); chk("multi_25", 3'd5, 1'b1, 1'b1);
        iData = 8'hFF;        tick(); chk("all_ones", 3'd7, 1'b1, 1'b1);
        iData = 8'b0000_0011; tick(); chk("multi_03", 3'd1, 1'b1, 1'b1);
        iData = 8'b1000_0001; tick(); chk("multi_81", 3'd7, 1'b1, 1'b1);

        // Zero input versus index 0.
        iData = 8'h00;        tick(); chk("zero", 3'd0, 1'b0, 1'b0);
        iData = 8'b0000_0001; tick(); chk("bit0", 3'd0, 1'b1, 1'b0);

        // Enable hold.
        iData = 8'b0001_0000; tick(); chk("hold_load", 3'd4, 1'b1, 1'b0);
        iEn   = 1'b0;
        iData = 8'b0100_0000;
        tick();               chk("hold_1", 3'd4, 1'b1, 1'b0);
        tick();               chk("hold_2", 3'd4, 1'b1, 1'b0);
        iData = 8'b0110_0000;
        tick();               chk("hold_3", 3'd4, 1'b1, 1'b0);
        iData = 8'b0100_0000;
        iEn   = 1'b1;
        tick();               chk("hold_release", 3'd6, 1'b1, 1'b0);

        // Mid-stream reset pulse shorter than a clock period.
        iData = 8'b1000_0000; tick(); chk("pre_reset", 3'd7, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 3'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_released", 3'd0, 1'b0, 1'b0);
        tick();               chk("post_reset", 3'd7, 1'b1, 1'b0);

        // Reset wins over enable across an edge.
        rst = 1'b1;
        tick();               chk("reset_and_en", 3'd0, 1'b0, 1'b0);

        // Release with enable low keeps the cleared state until an enabled edge.
        iEn = 1'b0;
        rst = 1'b0;
        tick();               chk("release_en_low", 3'd0, 1'b0, 1'b0);
        iEn   = 1'b1;
        iData = 8'b0000_1100;
        tick();               chk("first_enabled", 3'd3, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
